// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one multicycle, single-op-in-flight
// FPU between NUM_REQ requesters. Handles grant, payload capture, issue
// handshake, result routing back to the owner, and flush/drain.
// Optional watchdog enabled by defining FPU_SHARE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no op owned; round-robin grant starting at rr_ptr
// ISSUE | captured op presented to the FPU until accepted
// WAIT  | op inside the FPU; waiting for its result
// RESP  | result held for the owner until it accepts
// DRAIN | flushed op still inside the FPU; its result is discarded
module fpu_share_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int PAYLOAD_W = 208,
    parameter int WIDTH     = 64,
    parameter int TIMEOUT   = 127
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    input  logic [NUM_REQ-1:0]           rsp_ready_i,
    output logic [WIDTH-1:0]             rsp_result_o,
    output logic [4:0]                   rsp_status_o,
    output logic                         fpu_valid_o,
    input  logic                         fpu_ready_i,
    output logic [PAYLOAD_W-1:0]         fpu_payload_o,
    input  logic                         fpu_result_valid_i,
    input  logic [WIDTH-1:0]             fpu_result_i,
    input  logic [4:0]                   fpu_status_i,
    output logic                         fpu_result_ready_o,
    input  logic                         flush_i,
    output logic                         busy_o,
    output logic                         timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CW    = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [4:0]           status_q, status_d;

    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [CW-1:0]        cand;
    logic                 tmo_hit;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!grant_vld && req_valid_i[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

`ifdef FPU_SHARE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 7) ? $clog2(TIMEOUT + 1) : 7;
    logic [CNT_W-1:0] tmo_cnt_q;

    // Watchdog restarts on every state change and counts while in WAIT or DRAIN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_d != state_q) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT || state_q == S_DRAIN) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    assign tmo_hit = (state_q == S_WAIT || state_q == S_DRAIN) &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT));
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state, captures and handshake outputs
    always_comb begin
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        owner_d            = owner_q;
        payload_d          = payload_q;
        result_d           = result_q;
        status_d           = status_q;
        req_ready_o        = '0;
        rsp_valid_o        = '0;
        fpu_valid_o        = 1'b0;
        fpu_result_ready_o = 1'b0;
        timeout_o          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush_i && grant_vld) begin
                    req_ready_o[grant_idx] = 1'b1;
                    payload_d = req_payload_i[int'(grant_idx)*PAYLOAD_W +: PAYLOAD_W];
                    owner_d   = grant_idx;
                    rr_ptr_d  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_valid_o = 1'b1;
                if (flush_i) begin
                    // An accepted op is already inside the FPU and must be drained
                    state_d = fpu_ready_i ? S_DRAIN : S_IDLE;
                end else if (fpu_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                fpu_result_ready_o = 1'b1;
                if (flush_i) begin
                    state_d = fpu_result_valid_i ? S_IDLE : S_DRAIN;
                end else if (fpu_result_valid_i) begin
                    result_d = fpu_result_i;
                    status_d = fpu_status_i;
                    state_d  = S_RESP;
                end else if (tmo_hit) begin
                    timeout_o = 1'b1;
                    result_d  = '0;
                    status_d  = 5'b10000;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rsp_valid_o[owner_q] = 1'b1;
                    if (rsp_ready_i[owner_q]) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                fpu_result_ready_o = 1'b1;
                if (fpu_result_valid_i) begin
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    timeout_o = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            payload_q <= '0;
            result_q  <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            payload_q <= payload_d;
            result_q  <= result_d;
            status_q  <= status_d;
        end
    end

    assign fpu_payload_o = payload_q;
    assign rsp_result_o  = result_q;
    assign rsp_status_o  = status_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: combinational grant table, directed multi-cycle
// sequences and a randomized run, all checked against a transaction-level model.
module tb_fpu_share_arbiter;

    localparam int N  = 2;
    localparam int PW = 208;
    localparam int W  = 64;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            clk_run = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*PW-1:0] req_payload_i = '0;
    logic [N-1:0]    rsp_valid_o;
    logic [N-1:0]    rsp_ready_i = '0;
    logic [W-1:0]    rsp_result_o;
    logic [4:0]      rsp_status_o;
    logic            fpu_valid_o;
    logic            fpu_ready_i = 1'b0;
    logic [PW-1:0]   fpu_payload_o;
    logic            fpu_result_valid_i = 1'b0;
    logic [W-1:0]    fpu_result_i = '0;
    logic [4:0]      fpu_status_i = '0;
    logic            fpu_result_ready_o;
    logic            flush_i = 1'b0;
    logic            busy_o;
    logic            timeout_o;

    always #5 if (clk_run) clk_i = ~clk_i;

    fpu_share_arbiter #(.NUM_REQ(N), .PAYLOAD_W(PW), .WIDTH(W), .TIMEOUT(127)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_payload_i(req_payload_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_payload_o(fpu_payload_o),
        .fpu_result_valid_i(fpu_result_valid_i), .fpu_result_i(fpu_result_i),
        .fpu_status_i(fpu_status_i), .fpu_result_ready_o(fpu_result_ready_o),
        .flush_i(flush_i), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int n_cmp = 0, n_fail = 0, cyc = 0;

    // transaction-level model of the shared FPU slot
    int            rr = 0, owner = 0;
    bit            live = 0, issued = 0, done = 0, killed = 0;
    logic [PW-1:0] m_payload;
    logic [W-1:0]  m_result;
    logic [4:0]    m_status;
    int            grants[$];

    // behavioural FPU
    bit            fpu_has = 0;
    int            fpu_lat = 0;
    logic [W-1:0]  fpu_res;
    logic [4:0]    fpu_st;

    // stimulus knobs (percent probabilities)
    int vld_pct[N], rsp_pct[N];
    int rdy_pct = 100, flush_pct = 0, lat_lo = 1, lat_hi = 1;
    bit fix_res = 0;
    logic [W-1:0] fix_val = '0;

    // observation marks for latency checks
    int t_grant, t_first_fv, t_rvalid, t_first_rsp, n_rsp_seen;
    logic [W-1:0] last_rsp_res;
    logic [N-1:0] last_rsp_vld;

    typedef struct {
        logic [N-1:0] vld;
        logic         flush;
        logic [N-1:0] exp_ready;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp_v);
        end
    endtask

    function automatic logic [PW-1:0] rand_pl();
        logic [7*32-1:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
        return t[PW-1:0];
    endfunction

    task automatic mark();
        t_grant = -1; t_first_fv = -1; t_rvalid = -1; t_first_rsp = -1; n_rsp_seen = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; req_valid_i = '0; rsp_ready_i = '0; fpu_ready_i = 1'b0;
        fpu_result_valid_i = 1'b0; flush_i = 1'b0;
        live = 0; fpu_has = 0; rr = 0; grants.delete();
        #1;
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_fpu_valid", fpu_valid_o, 0);
        chk("rst_res_ready", fpu_result_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_payload", fpu_payload_o, 0);
        chk("rst_result", rsp_result_o, 0);
        chk("rst_status", rsp_status_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // one clock: drive at negedge, compare before posedge, advance model
    task automatic step();
        int g, idx;
        logic [N-1:0] er, erv;
        bit just_issued;
        @(negedge clk_i);
        cyc++;
        for (int i = 0; i < N; i++) begin
            req_valid_i[i] = ($urandom_range(99) < vld_pct[i]);
            rsp_ready_i[i] = ($urandom_range(99) < rsp_pct[i]);
            req_payload_i[i*PW +: PW] = rand_pl();
        end
        fpu_ready_i        = ($urandom_range(99) < rdy_pct);
        flush_i            = ($urandom_range(99) < flush_pct);
        fpu_result_valid_i = fpu_has && (fpu_lat == 0);
        fpu_result_i       = fpu_result_valid_i ? fpu_res : {$urandom(), $urandom()};
        fpu_status_i       = fpu_result_valid_i ? fpu_st : 5'($urandom());
        #1;
        g = -1;
        if (!live && !flush_i)
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (g < 0 && req_valid_i[idx]) g = idx;
            end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        erv = '0;
        if (live && done && !flush_i) erv[owner] = 1'b1;
        chk("req_ready", req_ready_o, er);
        chk("fpu_valid", fpu_valid_o, live && !issued);
        if (live && !issued) chk("fpu_payload", fpu_payload_o, m_payload);
        chk("fpu_res_ready", fpu_result_ready_o, live && issued && !done);
        chk("rsp_valid", rsp_valid_o, erv);
        if (live && done) begin
            chk("rsp_result", rsp_result_o, m_result);
            chk("rsp_status", rsp_status_o, m_status);
        end
        chk("busy", busy_o, live);
`ifndef FPU_SHARE_TIMEOUT_EN
        chk("timeout", timeout_o, 0);
`endif
        if (g >= 0 && t_grant < 0) t_grant = cyc;
        if (fpu_valid_o && t_first_fv < 0) t_first_fv = cyc;
        if (fpu_result_valid_i && t_rvalid < 0) t_rvalid = cyc;
        if (rsp_valid_o != 0) begin
            n_rsp_seen++;
            if (t_first_rsp < 0) t_first_rsp = cyc;
            last_rsp_res = rsp_result_o;
            last_rsp_vld = rsp_valid_o;
        end
        just_issued = 0;
        if (g >= 0) begin
            live = 1; issued = 0; done = 0; killed = 0; owner = g;
            m_payload = req_payload_i[g*PW +: PW];
            rr = (g + 1) % N;
            grants.push_back(g);
        end else if (live && !issued) begin
            if (fpu_ready_i) begin
                issued = 1; killed = flush_i; just_issued = 1;
                fpu_has = 1;
                fpu_lat = int'($urandom_range(lat_hi, lat_lo)) - 1;
                fpu_res = fix_res ? fix_val : {$urandom(), $urandom()};
                fpu_st  = fix_res ? 5'd0 : 5'($urandom());
            end else if (flush_i) begin
                live = 0;
            end
        end else if (live && issued && !done) begin
            if (fpu_result_valid_i) begin
                fpu_has = 0;
                if (killed || flush_i) live = 0;
                else begin done = 1; m_result = fpu_result_i; m_status = fpu_status_i; end
            end else if (flush_i) begin
                killed = 1;
            end
        end else if (live && done) begin
            if (flush_i || rsp_ready_i[owner]) live = 0;
        end
        if (fpu_has && !just_issued && fpu_lat > 0) fpu_lat--;
    endtask

    task automatic set_knobs(input int v0, input int v1, input int r0, input int r1,
                             input int rdy, input int lo, input int hi);
        vld_pct[0] = v0; vld_pct[1] = v1; rsp_pct[0] = r0; rsp_pct[1] = r1;
        rdy_pct = rdy; lat_lo = lo; lat_hi = hi; flush_pct = 0;
    endtask

    initial begin
        int budget;
        tbl[0] = '{vld: 2'b00, flush: 1'b0, exp_ready: 2'b00};
        tbl[1] = '{vld: 2'b01, flush: 1'b0, exp_ready: 2'b01};
        tbl[2] = '{vld: 2'b10, flush: 1'b0, exp_ready: 2'b10};
        tbl[3] = '{vld: 2'b11, flush: 1'b0, exp_ready: 2'b01};
        tbl[4] = '{vld: 2'b11, flush: 1'b1, exp_ready: 2'b00};
        tbl[5] = '{vld: 2'b10, flush: 1'b1, exp_ready: 2'b00};
        set_knobs(0, 0, 100, 100, 100, 1, 1);

        // grant table in IDLE with rr_ptr=0, clock frozen low
        do_reset();
        @(negedge clk_i);
        clk_run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid_i = tbl[i].vld;
            flush_i     = tbl[i].flush;
            #1;
            chk($sformatf("tbl%0d_ready", i), req_ready_o, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_busy", i), busy_o, 0);
        end
        req_valid_i = '0; flush_i = 1'b0;
        clk_run = 1'b1;

        // A: requester 0 alone, FPU latency 5, fixed result
        do_reset(); mark();
        set_knobs(100, 0, 100, 100, 100, 5, 5);
        fix_res = 1; fix_val = 64'h3FF0000000000000;
        budget = 0;
        while (!(grants.size() == 1 && !live) && budget < 60) begin step(); budget++; end
        vld_pct[0] = 0;
        chk("A_done", budget < 60, 1);
        chk("A_issue_lat", t_first_fv, t_grant + 1);
        chk("A_rsp_lat", t_first_rsp, t_rvalid + 1);
        chk("A_rsp_vld", last_rsp_vld, 2'b01);
        chk("A_result", last_rsp_res, 64'h3FF0000000000000);
        step();
        chk("A_busy_after", busy_o, 0);
        fix_res = 0;

        // B: both valid continuously -> 0,1,0,1
        do_reset();
        set_knobs(100, 100, 100, 100, 100, 1, 3);
        budget = 0;
        while (!(grants.size() >= 4 && !live) && budget < 100) begin step(); budget++; end
        chk("B_done", budget < 100, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("B_grant%0d", i), grants[i], i % 2);

        // C: FPU stalls 3 cycles in ISSUE
        do_reset();
        set_knobs(0, 100, 100, 100, 0, 2, 2);
        budget = 0;
        while (!(live && !issued) && budget < 10) begin step(); budget++; end
        vld_pct[1] = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("C_fv_held", fpu_valid_o, 1);
            chk("C_payload_held", fpu_payload_o, m_payload);
        end
        rdy_pct = 100;
        step();
        chk("C_accept", fpu_valid_o, 1);
        step();
        chk("C_wait", fpu_result_ready_o, 1);
        budget = 0;
        while (live && budget < 20) begin step(); budget++; end
        chk("C_done", live, 0);

        // D: flush in WAIT, result later drained, next grant follows
        do_reset(); mark();
        set_knobs(100, 0, 100, 100, 100, 6, 6);
        budget = 0;
        while (!(live && issued && !done) && budget < 10) begin step(); budget++; end
        vld_pct[0] = 0;
        flush_pct = 100; step(); flush_pct = 0;
        chk("D_drain_ready", fpu_result_ready_o, 1);
        budget = 0;
        while (live && budget < 20) begin step(); budget++; end
        chk("D_drained", live, 0);
        chk("D_no_rsp", n_rsp_seen, 0);
        vld_pct[0] = 100;
        step();
        chk("D_next_grant", req_ready_o, 2'b01);
        vld_pct[0] = 0;
        budget = 0;
        while (live && budget < 30) begin step(); budget++; end

        // E: owner holds off 10 cycles, non-owner ready ignored
        do_reset();
        set_knobs(100, 0, 0, 100, 100, 1, 2);
        budget = 0;
        while (!(live && done) && budget < 20) begin step(); budget++; end
        vld_pct[1] = 100;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("E_rsp_held", rsp_valid_o, 2'b01);
            chk("E_no_grant", req_ready_o, 2'b00);
        end
        rsp_pct[0] = 100; vld_pct[0] = 0; vld_pct[1] = 0;
        budget = 0;
        while (live && budget < 10) begin step(); budget++; end
        chk("E_done", live, 0);

        // randomized run with occasional mid-operation reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(20, 100),
                          $urandom_range(100), $urandom_range(10, 100), 1, $urandom_range(1, 6));
                flush_pct = $urandom_range(10);
            end
            if (c % 700 == 699) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Round-robin arbiter that shares one multicycle, single-op-in-flight FPU wrapper between NUM_REQ requesters (e.g. two issue ports or issue port plus debug).
- Sits between the requesters and the FPU top.
- Owns grant selection, payload capture, issue handshake, result routing back to the owner, and flush/drain.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- PAYLOAD_W, 208, width of the opaque op bundle: operands, rounding mode, op, formats, tag.
- WIDTH, 64, FPU result width.
- TIMEOUT, 127, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  one-hot accept.
- req_payload_i  in  NUM_REQ*PAYLOAD_W  per-requester op bundle.
- rsp_valid_o  out  NUM_REQ  one-hot response valid to the owner.
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- rsp_result_o  out  WIDTH  captured result.
- rsp_status_o  out  5  captured status {NV,DZ,OF,UF,NX}.
- fpu_valid_o  out  1  issue valid to FPU.
- fpu_ready_i  in  1  FPU accepts op.
- fpu_payload_o  out  PAYLOAD_W  registered op bundle.
- fpu_result_valid_i  in  1  FPU result valid.
- fpu_result_i  in  WIDTH  FPU result.
- fpu_status_i  in  5  FPU status.
- fpu_result_ready_o  out  1  ready for FPU result.
- flush_i  in  1  kill the in-flight op.
- busy_o  out  1  state != IDLE.
- timeout_o  out  1  watchdog pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, rr_ptr=0, owner=0; payload, result and status registers cleared.
  - All valid/ready outputs 0; busy_o=0.
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - grant = first set req_valid_i index searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - req_ready_o is combinational: one-hot of grant while in IDLE with flush_i=0 and any valid; else 0.
  - On grant: capture payload, owner<=grant, rr_ptr<=(grant+1) mod NUM_REQ, go to ISSUE.
  - No grant when flush_i=1.
- ISSUE: fpu_valid_o=1, fpu_payload_o=captured payload. On fpu_ready_i go to WAIT. fpu_payload_o stays stable while fpu_valid_o=1 and fpu_ready_i=0.
- WAIT:
  - fpu_result_ready_o=1.
  - On fpu_result_valid_i: capture result and status, go to RESP.
  - A result arriving in the same cycle as the ISSUE handshake is not possible; the FPU latency is >=1.
- RESP:
  - rsp_valid_o[owner]=1; rsp_result_o and rsp_status_o are held stable.
  - On rsp_ready_i[owner] go to IDLE.
  - rsp_ready_i from non-owners is ignored.
- Flush:
  - ISSUE with fpu_ready_i=1 same cycle: go to DRAIN.
  - ISSUE with fpu_ready_i=0: go to IDLE.
  - WAIT with fpu_result_valid_i=0: go to DRAIN.
  - WAIT with fpu_result_valid_i=1: discard the result, go to IDLE.
  - RESP: drop the response, go to IDLE.
  - DRAIN ignores flush.
- DRAIN: fpu_result_ready_o=1, no rsp_valid_o. On fpu_result_valid_i discard, go to IDLE.
- Latency:
  - Grant at cycle t gives fpu_valid_o at t+1.
  - Result valid at cycle r gives rsp_valid_o at r+1.
  - Back-to-back ops: the next grant is no earlier than the cycle after the RESP handshake.
- Fairness: a requester holding valid is granted within NUM_REQ grants.
- Reset mid-operation: returns to reset state immediately. Any FPU result arriving later is accepted only if the FSM is in WAIT/DRAIN; otherwise it is dropped.

Optional Feature:
- FPU_SHARE_TIMEOUT_EN defined:
  - 7-bit-or-wider counter clears on WAIT/DRAIN entry and increments each cycle in WAIT/DRAIN.
  - On reaching TIMEOUT in WAIT: pulse timeout_o one cycle, set result=0 and status=5'b10000 (NV), go to RESP.
  - On reaching TIMEOUT in DRAIN: pulse timeout_o, go to IDLE.
- Undefined: no counter, timeout_o tied 0, WAIT/DRAIN wait indefinitely.

Test Plan:
- Requester 0 only sends payload P0; FPU accepts next cycle and returns 64'h3FF0000000000000 with status 0 after 5 cycles -> rsp_valid_o=2'b01 one cycle later, result and status match, busy_o falls after the rsp handshake.
- Both valid continuously, rr_ptr=0 -> grant order 0,1,0,1 across four ops; req_ready_o is never two-hot.
- fpu_ready_i held 0 for 3 cycles in ISSUE -> fpu_valid_o stays 1 with fpu_payload_o unchanged; WAIT entered on the cycle fpu_ready_i=1.
- flush_i in WAIT, result arrives 4 cycles later -> DRAIN consumes it, no rsp_valid_o, next grant follows.
- rsp_ready_i[owner]=0 for 10 cycles in RESP, non-owner rsp_ready_i=1 -> response held stable, no new grant.
- With FPU_SHARE_TIMEOUT_EN and TIMEOUT=8, FPU never responds -> timeout_o pulses at WAIT entry+8, rsp delivers result 0 with NV set.
